// File: rtl/ioctl_loader_if.sv
// Source byte stream and ioctl write bus of the ROM/data download loader.
// A source byte moves on a rising clk_sys edge where src_valid && src_ready are both high.
// The source may assert src_valid at any time and must hold src_data with it.
// src_ready never depends on src_valid.
interface ioctl_loader_if;
    logic        src_valid;
    logic        src_ready;
    logic [7:0]  src_data;
    logic        ioctl_wait;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;

    modport master (
        input  src_valid, src_data, ioctl_wait,
        output src_ready, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index
    );

    modport slave (
        output src_valid, src_data, ioctl_wait,
        input  src_ready, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index
    );
endinterface

// File: rtl/ioctl_loader.sv
// Streams a counted run of source bytes through a small FIFO onto the ioctl write bus.
// Writes are spaced by WR_GAP idle cycles, and the download window lingers for TAIL cycles.
module ioctl_loader #(
    parameter int WR_GAP     = 3,
    parameter int TAIL       = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  index,
    input  logic [24:0] length,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [2:0]  state_o,
    ioctl_loader_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(WR_GAP + 1);
    localparam int TW = $clog2(TAIL + 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(WR_GAP - 1);
    localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_GAP, S_TAIL} state_e;

    state_e          state_q;
    logic [7:0]      fifo_q [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     count_q;
    logic [24:0]     len_q, acc_q, wrn_q;
    logic [GW-1:0]   gap_q;
    logic [TW-1:0]   tail_q;
    logic            wr_q, done_q;
    logic [24:0]     addr_q;
    logic [7:0]      dout_q, index_q;

    logic fill_state, fifo_full, src_ready, push, issue;

    assign fill_state = (state_q == S_SETUP) || (state_q == S_XFER) || (state_q == S_GAP);
    assign fifo_full  = (count_q == CNT_FULL);
    assign src_ready  = fill_state && !fifo_full && (acc_q < len_q);
    assign push       = bus.src_valid && src_ready;
    // A write needs a byte in hand and a quiet downstream; abort cancels it outright.
    assign issue      = (state_q == S_XFER) && (count_q != '0) && !bus.ioctl_wait && !abort;

    always_ff @(posedge clk_sys) begin
        if (push) fifo_q[wptr_q] <= bus.src_data;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            len_q   <= '0;
            acc_q   <= '0;
            wrn_q   <= '0;
            gap_q   <= '0;
            tail_q  <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            index_q <= '0;
        end else begin
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            if (push) begin
                wptr_q <= wptr_q + PTR_ONE;
                acc_q  <= acc_q + 25'd1;
            end
            if (issue) rptr_q <= rptr_q + PTR_ONE;
            case ({push, issue})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: ;
            endcase

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_SETUP;
                        index_q <= index;
                        len_q   <= length;
                        acc_q   <= '0;
                        wrn_q   <= '0;
                        wptr_q  <= '0;
                        rptr_q  <= '0;
                        count_q <= '0;
                    end
                end
                S_SETUP: begin
                    tail_q  <= '0;
                    state_q <= (len_q == 25'd0) ? S_TAIL : S_XFER;
                end
                S_XFER: begin
                    if (issue) begin
                        wr_q    <= 1'b1;
                        addr_q  <= wrn_q;
                        dout_q  <= fifo_q[rptr_q];
                        wrn_q   <= wrn_q + 25'd1;
                        gap_q   <= '0;
                        tail_q  <= '0;
                        state_q <= (wrn_q + 25'd1 == len_q) ? S_TAIL : S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) state_q <= S_XFER;
                    else                   gap_q   <= gap_q + GW'(1);
                end
                S_TAIL: begin
                    // The strobe cycle of the final write is not part of the tail.
                    if (!wr_q) begin
                        if (tail_q == TAIL_LAST) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            tail_q <= tail_q + TW'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (abort && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
                wr_q    <= 1'b0;
                done_q  <= 1'b0;
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
            end
        end
    end

    assign bus.src_ready      = src_ready;
    assign bus.ioctl_download = (state_q != S_IDLE);
    assign bus.ioctl_wr       = wr_q;
    assign bus.ioctl_addr     = addr_q;
    assign bus.ioctl_dout     = dout_q;
    assign bus.ioctl_index    = index_q;
    assign busy               = (state_q != S_IDLE);
    assign done               = done_q;
    assign state_o            = state_q;
endmodule

// File: tb/tb_ioctl_loader.sv
// Scoreboarded bench for ioctl_loader: the source driver queues each expected write,
// and a negedge monitor pops the queue and checks every write, gap, tail and done pulse.
module tb_ioctl_loader;
    localparam int WR_GAP = 3;
    localparam int TAIL   = 8;

    logic        clk_sys = 1'b0;
    logic        reset_n, start, abort;
    logic [7:0]  index;
    logic [24:0] length;
    logic        busy, done;
    logic [2:0]  state_o;

    ioctl_loader_if bus();

    ioctl_loader #(.WR_GAP(WR_GAP), .TAIL(TAIL), .FIFO_DEPTH(4)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .start   (start),
        .index   (index),
        .length  (length),
        .abort   (abort),
        .busy    (busy),
        .done    (done),
        .state_o (state_o),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int          checks = 0, passed = 0;
    logic [40:0] exp_q[$];
    logic [40:0] exp_e;
    logic [7:0]  exp_index = 8'h00;
    int          wr_total = 0, done_cnt = 0, acc_cnt = 0;
    int          low_run = 0, dl_run = 0;
    bit          win_wr = 1'b0, src_stop = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every strobe must match the oldest queued byte and respect the spacing rules.
    always @(negedge clk_sys) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (win_wr) check("tail_after_last_wr", low_run, TAIL);
            else        check("tail_without_wr", dl_run, 1 + TAIL);
        end
        if (bus.ioctl_download !== 1'b1) begin
            win_wr  = 1'b0;
            low_run = 0;
            dl_run  = 0;
        end else begin
            dl_run++;
            if (bus.ioctl_wr === 1'b1) begin
                wr_total++;
                if (exp_q.size() == 0) begin
                    check("wr_expected", exp_q.size(), 1);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("wr_index_addr_data", {bus.ioctl_index, bus.ioctl_addr, bus.ioctl_dout}, exp_e);
                end
                if (win_wr) check("wr_gap", low_run, WR_GAP);
                win_wr  = 1'b1;
                low_run = 0;
            end else begin
                low_run++;
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_start(input logic [7:0] idx, input logic [24:0] len, input bit with_abort);
        exp_index = idx;
        index     = idx;
        length    = len;
        start     = 1'b1;
        abort     = with_abort;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_busy", busy, 1);
        check("start_index_latched", bus.ioctl_index, idx);
    endtask

    task automatic send_bytes(input int n, input logic [7:0] base, input bit toggle);
        int i   = 0;
        int cyc = 0;
        bit ph  = 1'b0;
        while (i < n && !src_stop && cyc < 400) begin
            bus.src_data  = base + 8'(i);
            bus.src_valid = toggle ? ph : 1'b1;
            ph = !ph;
            @(negedge clk_sys);
            if (bus.src_valid && bus.src_ready === 1'b1) begin
                exp_q.push_back({exp_index, 25'(i), bus.src_data});
                i++;
                acc_cnt++;
            end
            tick();
            cyc++;
        end
        if (!src_stop) begin
            check("src_all_accepted", i, n);
            if (n > 0) begin
                bus.src_valid = 1'b1;
                bus.src_data  = 8'hFF;
                @(negedge clk_sys);
                check("src_ready_beyond_len", bus.src_ready, 0);
                tick();
            end
        end
        bus.src_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int cyc = 0;
        while (done_cnt == d0 && cyc < 300) begin
            tick();
            cyc++;
        end
        check("done_seen", done_cnt, d0 + 1);
        repeat (3) tick();
        check("done_single", done_cnt, d0 + 1);
        check("exp_q_drained", exp_q.size(), 0);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        int w0, d0, a0;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; index = 8'h00; length = '0;
        bus.src_valid = 1'b0; bus.src_data = 8'h00; bus.ioctl_wait = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {bus.ioctl_download, bus.ioctl_wr, bus.ioctl_addr, bus.ioctl_dout,
                                bus.ioctl_index, bus.src_ready, busy, done}, 0);
        reset_n = 1'b1;
        tick();

        // Basic run, with abort raised alongside start in IDLE.
        d0 = done_cnt;
        do_start(8'h01, 25'd4, 1'b1);
        send_bytes(4, 8'hA0, 1'b0);
        wait_done(d0);

        // Zero-length download.
        d0 = done_cnt; w0 = wr_total;
        do_start(8'h66, 25'd0, 1'b0);
        wait_done(d0);
        check("len0_no_wr", wr_total, w0);

        // Downstream stall: FIFO fills to four and no write issues.
        d0 = done_cnt; w0 = wr_total; a0 = acc_cnt;
        bus.ioctl_wait = 1'b1;
        do_start(8'h44, 25'd6, 1'b0);
        fork
            send_bytes(6, 8'h60, 1'b0);
            begin
                repeat (19) tick();
                check("stall_no_wr", wr_total, w0);
                check("stall_fifo_full", acc_cnt - a0, 4);
                check("stall_ready_low", bus.src_ready, 0);
                bus.ioctl_wait = 1'b0;
            end
        join
        wait_done(d0);
        check("stall_all_written", wr_total, w0 + 6);

        // Abort after the second write, then a fresh short download.
        d0 = done_cnt; w0 = wr_total;
        src_stop = 1'b0;
        do_start(8'h22, 25'd8, 1'b0);
        fork
            send_bytes(8, 8'h10, 1'b0);
            begin
                int cyc = 0;
                while (wr_total < w0 + 2 && cyc < 200) begin
                    tick();
                    cyc++;
                end
                check("abort_reach_2nd_wr", wr_total, w0 + 2);
                abort = 1'b1;
                src_stop = 1'b1;
                tick();
                abort = 1'b0;
                check("abort_download_low", bus.ioctl_download, 0);
                check("abort_addr_held", bus.ioctl_addr, 1);
            end
        join
        exp_q.delete();
        repeat (12) tick();
        check("abort_no_more_wr", wr_total, w0 + 2);
        check("abort_no_done", done_cnt, d0);
        src_stop = 1'b0;
        do_start(8'h33, 25'd2, 1'b0);
        send_bytes(2, 8'h50, 1'b0);
        wait_done(d0);

        // Source valid every other cycle, and a start while busy that must be ignored.
        d0 = done_cnt; w0 = wr_total;
        do_start(8'h55, 25'd5, 1'b0);
        fork
            send_bytes(5, 8'hC0, 1'b1);
            begin
                repeat (6) tick();
                start = 1'b1; index = 8'hEE; length = 25'd1;
                tick();
                start = 1'b0;
            end
        join
        wait_done(d0);
        check("toggle_wr_count", wr_total, w0 + 5);

        // Reset mid-transfer with start held high.
        w0 = wr_total;
        do_start(8'h77, 25'd4, 1'b0);
        fork
            send_bytes(4, 8'h90, 1'b0);
            begin
                int cyc = 0;
                while (wr_total < w0 + 1 && cyc < 100) begin
                    tick();
                    cyc++;
                end
                check("reset_reach_wr", wr_total, w0 + 1);
                reset_n = 1'b0; start = 1'b1; index = 8'hAB; length = 25'd3;
                src_stop = 1'b1;
                tick();
                check("midreset_outputs", {bus.ioctl_download, bus.ioctl_wr, bus.ioctl_addr, bus.ioctl_dout,
                                           bus.ioctl_index, bus.src_ready, busy, done}, 0);
                repeat (3) tick();
                check("reset_start_ignored", {bus.ioctl_download, bus.ioctl_index, busy, state_o}, 0);
                start = 1'b0;
                reset_n = 1'b1;
            end
        join
        exp_q.delete();
        repeat (4) tick();
        check("post_reset_idle", {bus.ioctl_download, busy, done}, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/ioctl_loader.md
IOCTL_LOADER -- requirements
Module: ioctl_loader

Interface
REQ-001 Parameter WR_GAP, default 3: minimum idle cycles with ioctl_wr low between consecutive ioctl_wr pulses.
REQ-002 Parameter TAIL, default 8: cycles ioctl_download stays high after the last write.
REQ-003 Parameter FIFO_DEPTH, default 4: source byte buffer entries, power of two.
REQ-004 clk_sys  in  1  sole clock; all logic rising-edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin a download; honoured only in IDLE.
REQ-007 index  in  8  download index, latched on accepted start.
REQ-008 length  in  25  byte count, latched on accepted start.
REQ-009 abort  in  1  cancel the current download.
REQ-010 src_valid / src_ready  in / out  1 / 1  source byte handshake; transfer when both high.
REQ-011 src_data  in  8  source byte.
REQ-012 ioctl_wait  in  1  downstream stall; no write issues while high.
REQ-013 ioctl_download  out  1  download window active.
REQ-014 ioctl_wr  out  1  single-cycle write strobe.
REQ-015 ioctl_addr / ioctl_dout / ioctl_index  out  25 / 8 / 8  write address, data and index.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 done  out  1  one-cycle pulse on normal completion.

Function
REQ-018 States: IDLE, SETUP, XFER, GAP, TAIL.
REQ-019 IDLE + start -> SETUP; latch index into ioctl_index and length; clear the byte counters.
REQ-020 SETUP lasts exactly 1 cycle with ioctl_download=1 and ioctl_wr=0, then goes to XFER, or to TAIL if length=0.
REQ-021 ioctl_download is high in SETUP, XFER, GAP and TAIL, and low in IDLE.
REQ-022 src_ready = (state in SETUP/XFER/GAP) and FIFO not full and bytes accepted < length.
REQ-023 A simultaneous FIFO push and pop is legal in any non-full state; occupancy stays unchanged.
REQ-024 XFER issues a write when the FIFO is non-empty and ioctl_wait=0: ioctl_wr=1 for one cycle, with ioctl_dout = FIFO head and ioctl_addr = bytes written so far.
REQ-025 The first write uses address 0, and addresses increase by 1 per write.
REQ-026 ioctl_addr and ioctl_dout hold their values until the next write.
REQ-027 After each write: go to TAIL if bytes written = length; otherwise go to GAP for WR_GAP cycles, then back to XFER.
REQ-028 ioctl_wait rising in the same cycle a write would issue suppresses that write.
REQ-029 While ioctl_wait is high the write stays pending and the FIFO continues to fill.
REQ-030 TAIL counts TAIL cycles, then goes to IDLE; done=1 in the first IDLE cycle only.
REQ-031 abort in any non-IDLE state -> IDLE on the next edge: FIFO flushed, ioctl_download=0, no done; ioctl_index and ioctl_addr hold their values.
REQ-032 start asserted while busy is ignored.
REQ-033 start and abort together in IDLE: the start is accepted.
REQ-034 Bytes offered beyond length are never accepted (src_ready=0).

Reset
REQ-035 reset_n=0 at an edge, from any state including mid-transfer: state=IDLE, FIFO empty, counters 0, and all outputs 0 (ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, src_ready, busy, done).

Verification
REQ-036 index=0x01, length=4, source always valid with bytes A0..A3, ioctl_wait=0 -> four wr pulses at addr 0..3 with data A0..A3, each pulse followed by exactly 3 low wr cycles before the next; download stays high 8 cycles after the last pulse; done pulses once.
REQ-037 length=0 -> download high for 1 SETUP cycle plus 8 TAIL cycles, no wr pulse, then done.
REQ-038 length=6, ioctl_wait held high for 20 cycles from SETUP -> no wr during the stall; src_ready drops after 4 bytes (FIFO full); after release all 6 bytes are written in order at addr 0..5.
REQ-039 abort after the 2nd write of length=8 -> download low next cycle, no further wr, no done; a following start with length=2 writes addr 0..1 with fresh source data.
REQ-040 reset_n low mid-XFER -> all outputs 0 on the next cycle; start ignored while reset_n=0.
REQ-041 Source valid toggling every other cycle with length=5 -> every byte is written exactly once, in order, with no duplicate or dropped write.
